// File: rtl/cdr_loop_filter.sv
// Bang-bang CDR loop filter: integrates up/dn votes and emits single-cycle inc/dec
// rotator steps, followed by a vote hold-off. Lock detect is built only with CDR_LOCK_DETECT_EN.
//
// state | meaning
// TRACK | votes integrated into acc; threshold crossing issues a correction
// HOLD  | votes ignored, acc held at 0 for HOLDOFF cycles after a correction
module cdr_loop_filter #(
    parameter int ACC_W   = 5,
    parameter int THRESH  = 8,
    parameter int HOLDOFF = 3,
    parameter int LOCK_N  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    up,
    input  logic                    dn,
    output logic                    inc,
    output logic                    dec,
    output logic signed [ACC_W-1:0] acc,
    output logic                    locked
);

    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = (HOLDOFF > 0) ? HW'(HOLDOFF - 1) : '0;
    localparam logic signed [ACC_W:0] THR_P = (ACC_W + 1)'(THRESH);
    localparam logic signed [ACC_W:0] THR_N = -THR_P;

    if (THRESH < 1 || THRESH > (2 ** (ACC_W - 1)) - 1 || HOLDOFF < 0 || LOCK_N < 1)
    begin : g_param_err
        $error("cdr_loop_filter: illegal parameter value");
    end

    typedef enum logic {TRACK = 1'b0, HOLD = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    inc_q, inc_d;
    logic                    dec_q, dec_d;
    logic [HW-1:0]           hold_q, hold_d;
    logic signed [ACC_W:0]   vote;
    logic signed [ACC_W:0]   acc_next;
    logic                    hit_p, hit_n;

    // One extra bit of headroom so the compare is exact before the clear.
    always_comb begin
        vote = '0;
        if (up && !dn) vote = {{ACC_W{1'b0}}, 1'b1};
        else if (dn && !up) vote = '1;
        acc_next = {acc_q[ACC_W-1], acc_q} + vote;
        hit_p    = (acc_next >= THR_P);
        hit_n    = (acc_next <= THR_N);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= TRACK;
            hold_q  <= '0;
            acc_q   <= '0;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            acc_q   <= acc_d;
            inc_q   <= inc_d;
            dec_q   <= dec_d;
        end
    end

    // Hold counter is loaded with HOLDOFF-1 and leaves HOLD on the edge it reads zero.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            TRACK: begin
                if ((hit_p || hit_n) && (HOLDOFF > 0)) begin
                    state_d = HOLD;
                    hold_d  = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (hold_q == '0) state_d = TRACK;
                else hold_d = hold_q - HW'(1);
            end
            default: state_d = TRACK;
        endcase
    end

    always_comb begin
        acc_d = acc_q;
        inc_d = 1'b0;
        dec_d = 1'b0;
        if (state_q == TRACK) begin
            if (hit_p) begin
                inc_d = 1'b1;
                acc_d = '0;
            end else if (hit_n) begin
                dec_d = 1'b1;
                acc_d = '0;
            end else begin
                acc_d = acc_next[ACC_W-1:0];
            end
        end
    end

    assign inc = inc_q;
    assign dec = dec_q;
    assign acc = acc_q;

`ifdef CDR_LOCK_DETECT_EN
    localparam int AW = $clog2(LOCK_N + 1);
    localparam logic [AW-1:0] LOCK_LD = AW'(LOCK_N);

    logic          dir_vld_q;
    logic          dir_up_q;
    logic [AW-1:0] alt_q;

    // Driven from the registered pulses so locked moves on the cycle after a correction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dir_vld_q <= 1'b0;
            dir_up_q  <= 1'b0;
            alt_q     <= '0;
        end else if (inc_q || dec_q) begin
            dir_vld_q <= 1'b1;
            dir_up_q  <= inc_q;
            if (dir_vld_q) begin
                if (inc_q != dir_up_q) begin
                    if (alt_q != LOCK_LD) alt_q <= alt_q + AW'(1);
                end else begin
                    alt_q <= '0;
                end
            end
        end
    end

    assign locked = (alt_q == LOCK_LD);
`else
    assign locked = 1'b0;
`endif

endmodule
